// File: rtl/i2c_target_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_target_regs                                               |
// | Purpose  : I2C target exposing a byte-wide register bank with an auto-   |
// |            incrementing pointer; fabric side can preload bank contents.  |
// | Option   : define I2C_TGT_GLITCH_FILTER_EN for a 3-sample bus filter.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h68,
    parameter int         PTR_W       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl,
    input  logic             sda_i,
    output logic             sda_oe,
    input  logic             host_we,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic             wr_valid,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy
);
    localparam int DEPTH = 2 ** PTR_W;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_WAIT_STOP = 4'd9
    } state_t;

    logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
    logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
    logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic scl_f, sda_f;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             rw_q, rw_d;
    logic             nack_q, nack_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             wr_valid_q, wr_valid_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [7:0]       bank_q [DEPTH];
    logic [7:0]       bank_d [DEPTH];
    logic [7:0]       rd_byte;

    always_comb begin
        scl_s1_d   = scl;
        scl_s2_d   = scl_s1_q;
        sda_s1_d   = sda_i;
        sda_s2_d   = sda_s1_q;
        scl_prev_d = scl_f;
        sda_prev_d = sda_f;
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic scl_h1_q, scl_h1_d, scl_h2_q, scl_h2_d;
    logic sda_h1_q, sda_h1_d, sda_h2_q, sda_h2_d;

    always_comb begin
        scl_h1_d = scl_s2_q;
        scl_h2_d = scl_h1_q;
        sda_h1_d = sda_s2_q;
        sda_h2_d = sda_h1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_h1_q <= 1'b1;
            scl_h2_q <= 1'b1;
            sda_h1_q <= 1'b1;
            sda_h2_q <= 1'b1;
        end else begin
            scl_h1_q <= scl_h1_d;
            scl_h2_q <= scl_h2_d;
            sda_h1_q <= sda_h1_d;
            sda_h2_q <= sda_h2_d;
        end
    end

    // The previous filtered value is held until three samples agree.
    assign scl_f = ((scl_s2_q == scl_h1_q) && (scl_h1_q == scl_h2_q)) ? scl_s2_q : scl_prev_q;
    assign sda_f = ((sda_s2_q == sda_h1_q) && (sda_h1_q == sda_h2_q)) ? sda_s2_q : sda_prev_q;
`else
    assign scl_f = scl_s2_q;
    assign sda_f = sda_s2_q;
`endif

    assign scl_rise  = scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f & scl_prev_q;
    assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
    assign rd_byte   = bank_q[ptr_q];

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        nack_d     = nack_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        bank_d     = bank_q;

        // Host write first so that a bus write to the same byte overrides it.
        if (host_we) begin
            bank_d[host_addr] = host_wdata;
        end

        if (stop_det) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise && (bit_cnt_q != 4'd8)) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[7:1] == TARGET_ADDR) begin
                            state_d  = ST_ADDR_ACK;
                            sda_oe_d = 1'b1;
                            rw_d     = shift_q[0];
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            state_d  = ST_RDATA;
                            shift_d  = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            state_d  = ST_PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise && (bit_cnt_q != 4'd8)) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                        bit_cnt_d = 4'd0;
                        state_d   = ST_PTR_ACK;
                        sda_oe_d  = 1'b1;
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall) begin
                        ptr_d    = shift_q[PTR_W-1:0];
                        sda_oe_d = 1'b0;
                        state_d  = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (scl_rise && (bit_cnt_q != 4'd8)) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                        bit_cnt_d     = 4'd0;
                        bank_d[ptr_q] = shift_q;
                        wr_valid_d    = 1'b1;
                        wr_addr_d     = ptr_q;
                        wr_data_d     = shift_q;
                        ptr_d         = ptr_q + PTR_W'(1);
                        sda_oe_d      = 1'b1;
                        state_d       = ST_WDATA_ACK;
                    end
                end
                ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise && (bit_cnt_q != 4'd8)) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b0;
                        ptr_d     = ptr_q + PTR_W'(1);
                        state_d   = ST_RDATA_ACK;
                    end else if (scl_fall && (bit_cnt_q != 4'd0)) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        nack_d = sda_f;
                    end else if (scl_fall) begin
                        if (nack_q) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            state_d  = ST_RDATA;
                            shift_d  = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            nack_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= 8'h00;
            end
        end else begin
            scl_s1_q   <= scl_s1_d;
            scl_s2_q   <= scl_s2_d;
            sda_s1_q   <= sda_s1_d;
            sda_s2_q   <= sda_s2_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            nack_q     <= nack_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            bank_q     <= bank_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule
`default_nettype wire
